// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry instruction FIFO with flush; head reads zero when empty
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   occupancy,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   count;

  // slot0 is always the head; a pop shifts slot1 forward
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (push && pop) begin
      if (count == 2'd2) begin
        slot0 <= slot1;
        slot1 <= push_entry;
      end else begin
        slot0 <= push_entry;
      end
    end else if (push) begin
      if (count == 2'd0) begin
        slot0 <= push_entry;
      end else begin
        slot1 <= push_entry;
      end
      count <= count + 2'd1;
    end else if (pop) begin
      slot0 <= slot1;
      count <= count - 2'd1;
    end
  end

  assign occupancy  = count;
  assign head_valid = (count != 2'd0);
  assign head_entry = head_valid ? slot0 : '0;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imemory issue/inflight tracking, redirect flush and delivery counter
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic [31:0] imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_insn,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0]  pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         issue;
  logic         push;
  logic         pop;
  logic [2:0]   level;
  logic [1:0]   occupancy;
  logic         head_valid;
  fetch_entry_t head_entry;
  fetch_entry_t push_entry;

  assign pop  = head_valid && out_ready;
  assign push = inflight && !redirect_valid;

  // Slots committed after this edge: what stays buffered plus what is already on its way
  assign level = {1'b0, occupancy} - {2'b00, pop} + {2'b00, inflight};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  issue = !redirect_valid && (level < 3'(BUF_DEPTH));
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= word_align(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign push_entry.pc   = inflight_pc;
  assign push_entry.insn = imem_data_out;

  fetch_buffer u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .occupancy  (occupancy),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  assign imem_address    = pc;
  assign imem_read_write = 32'h0;
  assign imem_data_in    = 32'h0;

  assign out_valid = head_valid;
  assign out_pc    = head_entry.pc;
  assign out_insn  = head_entry.insn;

endmodule
